// File: rtl/sprite_layer_renderer_if.sv
// Sprite ROM and palette bus between the renderer and its external memories.
// The renderer is the master: it drives the address, and the palette index follows the ROM data.
interface sprite_layer_renderer_if #(
  parameter int ADDR_W = 15,
  parameter int IDX_W  = 4
);
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (
    output rom_address,
    output pal_index,
    input  rom_q,
    input  pal_red,
    input  pal_green,
    input  pal_blue
  );

  modport slave (
    input  rom_address,
    input  pal_index,
    output rom_q,
    output pal_red,
    output pal_green,
    output pal_blue
  );
endinterface

// File: rtl/sprite_layer_renderer.sv
// Positioned, power-of-two scaled, animated sprite renderer with a fixed 3-cycle latency.
// Optional SPRITE_FLIP_EN adds a flip_h input that mirrors the sprite horizontally.
module sprite_layer_renderer #(
  parameter int SPR_W           = 70,
  parameter int SPR_H           = 70,
  parameter int FRAMES          = 4,
  parameter int SCALE_LOG2      = 0,
  parameter int ANIM_DIV        = 8,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ADDR_W          = $clog2(FRAMES*SPR_W*SPR_H)
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       anim_en,
`ifdef SPRITE_FLIP_EN
  input  logic       flip_h,
`endif
  sprite_layer_renderer_if.master mem,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       opaque
);

  localparam int VW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int FPIX  = SPR_W * SPR_H;
  localparam int W_LIM = SPR_W << SCALE_LOG2;
  localparam int H_LIM = SPR_H << SCALE_LOG2;

  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic [VW-1:0]     vid_q, vid_d;
  logic [FW-1:0]     anim_q, anim_d;
  logic [ADDR_W-1:0] rom_address_q;
  logic              hit1_q, blank1_q;
  logic              hit2_q, blank2_q;
  logic [3:0]        red_q, green_q, blue_q;
  logic              opaque_q;
`ifdef SPRITE_FLIP_EN
  logic              flip_q, flip_d;
`endif

  logic              frame_start;
  logic signed [10:0] rel_x, rel_y;
  logic [31:0]       rx_u, ry_u, col, row, addr32;
  logic              hit;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  // Next-state values also feed stage 0, so pixel (0,0) already sees the new frame
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vid_d   = vid_q;
    anim_d  = anim_q;
`ifdef SPRITE_FLIP_EN
    flip_d  = flip_q;
`endif
    if (frame_start) begin
      pos_x_d = pos_x;
      pos_y_d = pos_y;
`ifdef SPRITE_FLIP_EN
      flip_d  = flip_h;
`endif
      if (anim_en) begin
        if (vid_q == VW'(ANIM_DIV-1)) begin
          vid_d  = '0;
          anim_d = (anim_q == FW'(FRAMES-1)) ? '0 : anim_q + 1'b1;
        end else begin
          vid_d  = vid_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rel_x = $signed({1'b0, DrawX} - {1'b0, pos_x_d});
    rel_y = $signed({1'b0, DrawY} - {1'b0, pos_y_d});
    rx_u  = 32'(rel_x[9:0]);
    ry_u  = 32'(rel_y[9:0]);
    hit   = !rel_x[10] && (rx_u < 32'(W_LIM)) &&
            !rel_y[10] && (ry_u < 32'(H_LIM));
    col   = rx_u >> SCALE_LOG2;
    row   = ry_u >> SCALE_LOG2;
`ifdef SPRITE_FLIP_EN
    if (flip_d) col = 32'(SPR_W-1) - col;
`endif
    addr32 = 32'(anim_d) * 32'(FPIX) + row * 32'(SPR_W) + col;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      vid_q         <= '0;
      anim_q        <= '0;
      rom_address_q <= '0;
      hit1_q        <= 1'b0;
      blank1_q      <= 1'b0;
      hit2_q        <= 1'b0;
      blank2_q      <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      opaque_q      <= 1'b0;
`ifdef SPRITE_FLIP_EN
      flip_q        <= 1'b0;
`endif
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vid_q         <= vid_d;
      anim_q        <= anim_d;
      rom_address_q <= hit ? addr32[ADDR_W-1:0] : '0;
      hit1_q        <= hit;
      blank1_q      <= blank;
      hit2_q        <= hit1_q;
      blank2_q      <= blank1_q;
`ifdef SPRITE_FLIP_EN
      flip_q        <= flip_d;
`endif
      if (blank2_q && hit2_q && (mem.rom_q != IDX_W'(TRANSPARENT_IDX))) begin
        red_q    <= mem.pal_red;
        green_q  <= mem.pal_green;
        blue_q   <= mem.pal_blue;
        opaque_q <= 1'b1;
      end else begin
        red_q    <= '0;
        green_q  <= '0;
        blue_q   <= '0;
        opaque_q <= 1'b0;
      end
    end
  end

  assign mem.rom_address = rom_address_q;
  assign mem.pal_index   = mem.rom_q;
  assign red             = red_q;
  assign green           = green_q;
  assign blue            = blue_q;
  assign opaque          = opaque_q;

endmodule

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
- Positioned, scaled, animated sprite renderer for the VGA pixel pipeline. Successor to the full-screen stretch renderer.
- Maps each (DrawX, DrawY) into a multi-frame sprite ROM at a programmable screen position with integer power-of-two scaling.
- Drives an external synchronous ROM and an external combinational palette.
- Emits registered 4-bit RGB plus an opaque flag, so a downstream compositor can layer sprites over a background.

Parameters:
- SPR_W, 70, sprite width in texels
- SPR_H, 70, sprite height in texels
- FRAMES, 4, animation frames stored back-to-back in ROM (frame f starts at f*SPR_W*SPR_H)
- SCALE_LOG2, 0, on-screen scale = 2^SCALE_LOG2 per axis (0..3)
- ANIM_DIV, 8, video frames per animation step (>=1)
- IDX_W, 4, palette index width
- TRANSPARENT_IDX, 0, palette index treated as transparent
- ADDR_W, $clog2(FRAMES*SPR_W*SPR_H), ROM address width

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active display region
- pos_x  in  10  sprite top-left column; latched at frame start
- pos_y  in  10  sprite top-left row; latched at frame start
- anim_en  in  1  1 = advance animation
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, valid 1 cycle after rom_address
- pal_index  out  IDX_W  palette index (= rom_q, combinational)
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index
- red, green, blue  out  4 each  registered pixel colour
- opaque  out  1  registered; 1 = sprite pixel drawn this cycle

Behaviour:
- Reset (sync, high) clears:
  - outputs: red/green/blue/opaque = 0, rom_address = 0
  - state: anim_frame = 0, vid_cnt = 0, latched pos = (0,0), all pipeline valid/blank/hit bits = 0
- Frame start: the cycle with DrawX==0 && DrawY==0.
  - Latch pos_x/pos_y into pos_l_x/pos_l_y.
  - If anim_en: vid_cnt increments; when vid_cnt==ANIM_DIV-1 it wraps to 0 and anim_frame increments modulo FRAMES (FRAMES-1 -> 0).
  - If anim_en==0: vid_cnt and anim_frame hold.
  - Mid-frame changes to pos_x/pos_y have no effect until the next frame start.
- Stage 0, combinational on the sampled inputs:
  - rel_x = {1'b0,DrawX} - {1'b0,pos_l_x} (11-bit signed); rel_y computed the same way.
  - hit = rel_x>=0 && rel_x<(SPR_W<<SCALE_LOG2) && rel_y>=0 && rel_y<(SPR_H<<SCALE_LOG2).
  - col = rel_x>>SCALE_LOG2; row = rel_y>>SCALE_LOG2.
  - address = anim_frame*SPR_W*SPR_H + row*SPR_W + col, computed at full width with no truncation before the final ADDR_W result.
- Edge N+1: rom_address <= hit ? address : 0. hit and blank are registered alongside it.
- Edge N+2: rom_q is valid (external ROM latency). hit and blank are delayed one more stage.
- Edge N+3 output register:
  - If d_blank && d_hit && rom_q!=TRANSPARENT_IDX: {red,green,blue} <= pal_*, opaque <= 1.
  - Otherwise: all colour outputs <= 0, opaque <= 0.
- Total latency from DrawX/DrawY/blank to red/green/blue/opaque: 3 cycles, fixed; the caller compensates for it.
- Clipping:
  - Sprites extending past column 639 or row 479 are clipped, with no wrap.
  - pos_x > DrawX gives negative rel_x, so no hit.
- The animation-frame change and the pos latch take effect starting with pixel (0,0) of the new frame. Pixels still in the pipeline use the old values.
- Reset mid-frame: the pipeline flushes immediately. The first valid output appears 3 cycles after Reset deasserts.

Optional Feature:
- Macro: SPRITE_FLIP_EN.
- Defined:
  - Adds input port flip_h (1 bit), latched at frame start together with pos.
  - When the latched value is 1, col = SPR_W-1-(rel_x>>SCALE_LOG2), mirroring the sprite horizontally.
- Undefined: flip_h port absent; no mirroring logic.

Test Plan:
- Reset held 5 cycles mid-line -> red/green/blue/opaque = 0 and rom_address = 0 throughout; first valid pixel output 3 cycles after Reset falls.
- pos=(100,50), SCALE_LOG2=0, frame 0, DrawX=100, DrawY=50 -> rom_address=0 at N+1; opaque=1 and RGB = palette of rom_q at N+3. DrawX=169 -> address 69. DrawX=170 -> opaque=0.
- SCALE_LOG2=1, pos=(0,0), DrawX=3, DrawY=5 -> rom_address = 2*70+1 = 141.
- rom_q == TRANSPARENT_IDX inside sprite, or blank=0 -> RGB=0, opaque=0.
- anim_en=1, ANIM_DIV=2, FRAMES=4: after 2 frame starts anim_frame=1 (pixel (pos) address 4900); after 8 it wraps to 0. anim_en=0 -> anim_frame frozen.
- pos_x changed mid-frame from 100 to 300 -> hits stay at column 100 until the next DrawX=0,DrawY=0, then move to 300. pos_x=620 -> hits only for columns 620..639.
